// File: rtl/serial_out_scheduler_pkg.sv
// Shared types for the serial_out command scheduler: FSM encoding, commit selector
// and the latched command flags.
package serial_out_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_ISSUE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] SEL_COMMIT = 4'hF;

    typedef struct packed {
        logic [3:0] sel;
        logic       start;
        logic       stop;
        logic       mode;
    } cmd_t;

endpackage

// File: rtl/serial_out_scheduler_ch_status.sv
// Per-channel status: mode register, busy bit and (with SYNC_START_EN) the
// pending-start bit. A start always wins over a same-cycle clear.
module ch_status
    import serial_out_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mode_we,
    input  logic mode_d,
    input  logic start_set,
    input  logic stop_clr,
    input  logic pend_set,
    input  logic pend_clr,
    input  logic done_tick,
    output logic mode,
    output logic busy,
    output logic pending
);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
            busy <= 1'b0;
        end else begin
            if (mode_we)
                mode <= mode_d;
            // Repeat-mode channels ignore done ticks; only a stop ends them.
            if (start_set)
                busy <= 1'b1;
            else if (stop_clr)
                busy <= 1'b0;
            else if (done_tick && !mode)
                busy <= 1'b0;
        end
    end

`ifdef SYNC_START_EN
    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (stop_clr || pend_clr)
            pending <= 1'b0;
        else if (pend_set)
            pending <= 1'b1;
    end
`else
    logic unused_pend;
    assign unused_pend = ^{pend_set, pend_clr};
    assign pending     = 1'b0;
`endif

endmodule

// File: rtl/serial_out_scheduler.sv
// Sequences decoded commands onto CH_NUM serial_out channels (load, start/stop pulse,
// busy tracking). Define SYNC_START_EN to arm starts as pending and launch them on commit.
module serial_out_scheduler
    import serial_out_scheduler_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [3:0]                 i_cmd_sel,
    input  logic                       i_cmd_start,
    input  logic                       i_cmd_stop,
    input  logic                       i_cmd_mode,
    input  logic [DATA_BIT-1:0]        i_cmd_output_pattern,
    input  logic [DATA_BIT-1:0]        i_cmd_freq_pattern,
    input  logic [CH_NUM-1:0]          i_ch_done_tick,
    output logic [CH_NUM-1:0]          o_ch_start,
    output logic [CH_NUM-1:0]          o_ch_stop,
    output logic [CH_NUM-1:0]          o_ch_mode,
    output logic [CH_NUM*DATA_BIT-1:0] o_ch_output_pattern,
    output logic [CH_NUM*DATA_BIT-1:0] o_ch_freq_pattern,
    output logic [CH_NUM-1:0]          o_busy,
    output logic                       o_done_tick,
    output logic                       o_err
);

    state_t                           state, state_nxt;
    cmd_t                             cmd;
    logic [DATA_BIT-1:0]              cmd_pat, cmd_frq;
    logic [CH_NUM-1:0][DATA_BIT-1:0]  out_pat, frq_pat;
    logic [CH_NUM-1:0]                sel_hit, ch_we, pend_set, pending;
    logic                             sel_ok, commit_ok, load_err, commit;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_sel
        assign sel_hit[n] = (cmd.sel == 4'(n));
    end

    assign sel_ok = |sel_hit;
`ifdef SYNC_START_EN
    assign commit_ok = (cmd.sel == SEL_COMMIT);
`else
    assign commit_ok = 1'b0;
`endif
    // Stop is never rejected; a start to a running channel is.
    assign load_err = sel_ok ? (!cmd.stop && cmd.start && |(sel_hit & o_busy)) : !commit_ok;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd     <= '0;
            cmd_pat <= '0;
            cmd_frq <= '0;
        end else if (state == S_IDLE && i_cmd_valid) begin
            cmd     <= '{sel: i_cmd_sel, start: i_cmd_start, stop: i_cmd_stop, mode: i_cmd_mode};
            cmd_pat <= i_cmd_output_pattern;
            cmd_frq <= i_cmd_freq_pattern;
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < CH_NUM; n++) begin
            if (rst) begin
                out_pat[n] <= '0;
                frq_pat[n] <= '0;
            end else if (ch_we[n]) begin
                out_pat[n] <= cmd_pat;
                frq_pat[n] <= cmd_frq;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_cmd_valid) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = load_err ? S_IDLE : S_ISSUE;
            S_ISSUE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = 1'b0;
        o_err       = 1'b0;
        o_done_tick = 1'b0;
        o_ch_start  = '0;
        o_ch_stop   = '0;
        ch_we       = '0;
        pend_set    = '0;
        commit      = 1'b0;
        case (state)
            S_IDLE: o_cmd_ready = !rst;
            S_LOAD: begin
                o_err = load_err;
                if (sel_ok && !cmd.stop && !load_err)
                    ch_we = sel_hit;
            end
            S_ISSUE: begin
                if (commit_ok) begin
                    commit     = 1'b1;
                    o_ch_start = pending;
                end else if (cmd.stop) begin
                    o_ch_stop = sel_hit;
                end else if (cmd.start) begin
`ifdef SYNC_START_EN
                    pend_set = sel_hit;
`else
                    o_ch_start = sel_hit;
`endif
                end
            end
            S_DONE:  o_done_tick = 1'b1;
            default: ;
        endcase
    end

    ch_status u_ch [CH_NUM-1:0] (
        .clk       (clk),
        .rst       (rst),
        .mode_we   (ch_we),
        .mode_d    ({CH_NUM{cmd.mode}}),
        .start_set (o_ch_start),
        .stop_clr  (o_ch_stop),
        .pend_set  (pend_set),
        .pend_clr  ({CH_NUM{commit}}),
        .done_tick (i_ch_done_tick),
        .mode      (o_ch_mode),
        .busy      (o_busy),
        .pending   (pending)
    );

    assign o_ch_output_pattern = out_pat;
    assign o_ch_freq_pattern   = frq_pat;

endmodule

// File: tb/tb_serial_out_scheduler.sv
// Randomized bench for serial_out_scheduler against a per-channel behavioural model;
// follows SYNC_START_EN the same way the design does.
module tb_serial_out_scheduler;

    localparam int DB = 32;
    localparam int CN = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic [3:0]           i_cmd_sel;
    logic                 i_cmd_start, i_cmd_stop, i_cmd_mode;
    logic [DB-1:0]        i_cmd_output_pattern, i_cmd_freq_pattern;
    logic [CN-1:0]        i_ch_done_tick;
    logic [CN-1:0]        o_ch_start, o_ch_stop, o_ch_mode, o_busy;
    logic [CN*DB-1:0]     o_ch_output_pattern, o_ch_freq_pattern;
    logic                 o_done_tick, o_err;

    always #5 clk = ~clk;

    serial_out_scheduler #(.DATA_BIT(DB), .CH_NUM(CN)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_cmd_valid          (i_cmd_valid),
        .o_cmd_ready          (o_cmd_ready),
        .i_cmd_sel            (i_cmd_sel),
        .i_cmd_start          (i_cmd_start),
        .i_cmd_stop           (i_cmd_stop),
        .i_cmd_mode           (i_cmd_mode),
        .i_cmd_output_pattern (i_cmd_output_pattern),
        .i_cmd_freq_pattern   (i_cmd_freq_pattern),
        .i_ch_done_tick       (i_ch_done_tick),
        .o_ch_start           (o_ch_start),
        .o_ch_stop            (o_ch_stop),
        .o_ch_mode            (o_ch_mode),
        .o_ch_output_pattern  (o_ch_output_pattern),
        .o_ch_freq_pattern    (o_ch_freq_pattern),
        .o_busy               (o_busy),
        .o_done_tick          (o_done_tick),
        .o_err                (o_err)
    );

    // Behavioural channel model
    logic [CN-1:0][DB-1:0] m_pat, m_frq;
    logic [CN-1:0]         m_mode, m_busy, m_pend;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CN-1:0] rand_done();
        return ($urandom_range(3) == 0) ? CN'($urandom) : '0;
    endfunction

    task automatic model_reset();
        m_pat = '0; m_frq = '0; m_mode = '0; m_busy = '0; m_pend = '0;
    endtask

    // One clock edge: done ticks clear one-shot channels, then stop/start of this cycle apply.
    task automatic edge_step(input logic [CN-1:0] done, input logic [CN-1:0] st_m,
                             input logic [CN-1:0] sp_m);
        i_ch_done_tick = done;
        @(posedge clk);
        m_busy = m_busy & ~(done & ~m_mode);
        m_busy = (m_busy & ~sp_m) | st_m;
        @(negedge clk);
        i_ch_done_tick = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_busy"}, o_busy, m_busy);
        chk({tag, "_mode"}, o_ch_mode, m_mode);
        chk({tag, "_pat"},  o_ch_output_pattern, m_pat);
        chk({tag, "_frq"},  o_ch_freq_pattern, m_frq);
    endtask

    task automatic idle(input logic [CN-1:0] done);
        edge_step(done, '0, '0);
        chk("idle_start", o_ch_start, '0);
        chk("idle_ready", o_cmd_ready, 1'b1);
        chk("idle_busy", o_busy, m_busy);
    endtask

    task automatic cmd(input logic [3:0] sel, input bit st, input bit sp, input bit md,
                       input logic [DB-1:0] p, input logic [DB-1:0] f,
                       input logic [CN-1:0] issue_done);
        logic [CN-1:0] oh, exp_st, exp_sp, pset;
        bit ok, err, commit;
        int idx;
        idx = int'(sel);
        ok = (idx < CN);
        oh = '0;
        if (ok) oh[idx] = 1'b1;
        commit = 1'b0;
`ifdef SYNC_START_EN
        commit = (sel == 4'hF);
`endif
        chk("ready_c0", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1; i_cmd_sel = sel; i_cmd_start = st; i_cmd_stop = sp;
        i_cmd_mode = md; i_cmd_output_pattern = p; i_cmd_freq_pattern = f;
        edge_step(rand_done(), '0, '0);
        i_cmd_valid = 1'b0;
        i_cmd_output_pattern = $urandom; i_cmd_freq_pattern = $urandom;
        // cycle 1: decision
        err = ok ? (st && !sp && m_busy[idx]) : !commit;
        chk("err_c1", o_err, err);
        chk("ready_c1", o_cmd_ready, 1'b0);
        chk("start_c1", o_ch_start | o_ch_stop, '0);
        if (err) begin
            edge_step(rand_done(), '0, '0);
            chk("err_c2", o_err, 1'b0);
            chk("ready_after_err", o_cmd_ready, 1'b1);
            check_state("after_err");
            return;
        end
        edge_step(rand_done(), '0, '0);
        if (ok && !sp) begin
            m_pat[idx] = p; m_frq[idx] = f; m_mode[idx] = md;
        end
        // cycle 2: issue
        exp_st = '0; exp_sp = '0; pset = '0;
        if (commit) exp_st = m_pend;
        else if (sp) exp_sp = oh;
        else if (st) begin
`ifdef SYNC_START_EN
            pset = oh;
`else
            exp_st = oh;
`endif
        end
        chk("start_c2", o_ch_start, exp_st);
        chk("stop_c2", o_ch_stop, exp_sp);
        chk("done_c2", o_done_tick, 1'b0);
        check_state("issue");
        edge_step(issue_done, exp_st, exp_sp);
        if (commit) m_pend = '0;
        m_pend = (m_pend & ~exp_sp) | pset;
        // cycle 3: done
        chk("done_c3", o_done_tick, 1'b1);
        chk("start_c3", o_ch_start, '0);
        chk("busy_c3", o_busy, m_busy);
        edge_step(rand_done(), '0, '0);
        chk("done_c4", o_done_tick, 1'b0);
        chk("ready_c4", o_cmd_ready, 1'b1);
        check_state("post");
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_sel = '0; i_cmd_start = 1'b0;
        i_cmd_stop = 1'b0; i_cmd_mode = 1'b0; i_cmd_output_pattern = '0;
        i_cmd_freq_pattern = '0; i_ch_done_tick = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", o_cmd_ready, 1'b0);
        chk("rst_pulses", {o_ch_start, o_ch_stop, o_done_tick, o_err}, '0);
        check_state("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", o_cmd_ready, 1'b1);

        // one-shot start on ch1, busy until its done tick
        cmd(4'd1, 1, 0, 0, 32'hA5A5_0F0F, 32'h0000_00FF, '0);
        idle('0);
        idle(3'b010);

        // repeat-mode ch0: second start rejected, done ignored, stop ends it
        cmd(4'd0, 1, 0, 1, 32'h1234_5678, 32'h0000_0010, '0);
        cmd(4'd0, 1, 0, 0, 32'hDEAD_BEEF, 32'h0000_0020, '0);
        idle(3'b001);
        cmd(4'd0, 0, 1, 0, 32'h0, 32'h0, '0);

        // out-of-range selector
        cmd(4'd7, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);

        // start issue colliding with a done tick
        cmd(4'd1, 1, 0, 0, 32'hCAFE_0001, 32'h0000_0003, 3'b010);

`ifdef SYNC_START_EN
        cmd(4'd1, 0, 1, 0, 32'h0, 32'h0, '0);
        cmd(4'd0, 1, 0, 0, 32'h0000_00A0, 32'h1, '0);
        cmd(4'd2, 1, 0, 0, 32'h0000_00A2, 32'h2, '0);
        chk("pend_before_commit", m_pend, 3'b101);
        cmd(4'hF, 0, 0, 0, 32'h0, 32'h0, '0);
        cmd(4'hF, 0, 0, 0, 32'h0, 32'h0, '0);
`else
        cmd(4'hF, 0, 0, 0, 32'h0, 32'h0, '0);
`endif

        // reset in cycle 1 of a start command
        chk("ready_pre_rst", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1; i_cmd_sel = 4'd2; i_cmd_start = 1'b1; i_cmd_stop = 1'b0;
        i_cmd_output_pattern = 32'h5555_AAAA;
        edge_step('0, '0, '0);
        i_cmd_valid = 1'b0;
        rst = 1'b1;
        edge_step('0, '0, '0);
        model_reset();
        chk("midrst_ready", o_cmd_ready, 1'b0);
        chk("midrst_pulses", {o_ch_start, o_ch_stop, o_done_tick, o_err}, '0);
        check_state("midrst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_step('0, '0, '0);
            chk("postrst_start", o_ch_start, '0);
            chk("postrst_ready", o_cmd_ready, 1'b1);
            check_state("postrst");
        end

        // randomized traffic
        for (int k = 0; k < 200; k++) begin
            int r;
            logic [3:0] s;
            r = $urandom_range(11);
            s = (r < 9) ? 4'($urandom_range(CN - 1)) : ((r == 9) ? 4'd7 : 4'hF);
            cmd(s, 1'($urandom), ($urandom_range(3) == 0), 1'($urandom),
                $urandom, $urandom, rand_done());
            repeat ($urandom_range(2)) idle(rand_done());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
